// File: rtl/qspi_flash_pkg.sv
// rtl/qspi_flash_pkg.sv - shared types and constants for the QSPI flash read sequencer
package qspi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP  = 3'd4
    } qspi_rd_state_e;

    localparam logic [7:0] CMD_READ_DEFAULT = 8'h03;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 24;
    localparam int DATA_BITS = 32;

endpackage

// File: rtl/qspi_sck_gen.sv
// rtl/qspi_sck_gen.sv - mode-0 SCK generator with rise/fall strobes at the toggling clk edge
module qspi_sck_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             enable,
    output logic             sck,
    output logic             rise_stb,
    output logic             fall_stb
);

    logic [DIV_W-1:0] cnt;
    logic             tc;

    // Strobes mark the clk edge on which sck is about to change.
    assign tc       = enable && (cnt == div);
    assign rise_stb = tc && !sck;
    assign fall_stb = tc && sck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!enable) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (tc) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qspi_flash_reader.sv
// rtl/qspi_flash_reader.sv - single-lane SPI READ (0x03) sequencer returning little-endian 32-bit words
module qspi_flash_reader
    import qspi_flash_pkg::*;
#(
    parameter int         DIV_W    = 8,
    parameter logic [7:0] CMD_READ = CMD_READ_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [23:0]      req_addr_i,
    output logic             rsp_valid_o,
    output logic [31:0]      rsp_data_o,
    output logic             busy_o,
    output logic             qspi_cs_n_o,
    output logic             qspi_sck_o,
    output logic [3:0]       qspi_dq_o,
    output logic [3:0]       qspi_dq_oe,
    input  logic [3:0]       qspi_dq_i
);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_CMD  = ST_CMD;
    localparam logic [2:0] S_ADDR = ST_ADDR;
    localparam logic [2:0] S_DATA = ST_DATA;
    localparam logic [2:0] S_GAP  = ST_GAP;

    logic [2:0]       state;
    logic [DIV_W-1:0] div_q;
    logic [31:0]      tx_shift;
    logic [31:0]      rx_shift;
    logic [5:0]       bit_cnt;
    logic [DIV_W:0]   gap_cnt;
    logic             sck_en;
    logic             rise_stb;
    logic             fall_stb;
    logic             last_bit;
    logic             unused_dq;

    assign unused_dq = ^{qspi_dq_i[3:2], qspi_dq_i[0]};
    assign sck_en    = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);

    qspi_sck_gen #(
        .DIV_W (DIV_W)
    ) u_sck_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .div      (div_q),
        .enable   (sck_en),
        .sck      (qspi_sck_o),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_comb begin
        last_bit = 1'b0;
        case (state)
            S_CMD:   last_bit = (bit_cnt == 6'(CMD_BITS - 1));
            S_ADDR:  last_bit = (bit_cnt == 6'(ADDR_BITS - 1));
            S_DATA:  last_bit = (bit_cnt == 6'(DATA_BITS - 1));
            default: last_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            div_q       <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            qspi_cs_n_o <= 1'b1;
            qspi_dq_o   <= 4'b1100;
            qspi_dq_oe  <= 4'b1100;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        state         <= S_CMD;
                        div_q         <= div_i;
                        // First bit goes out with CS; the register holds the bits still to send.
                        tx_shift      <= {CMD_READ[6:0], req_addr_i, 1'b0};
                        qspi_dq_o[0]  <= CMD_READ[7];
                        qspi_dq_oe[0] <= 1'b1;
                        qspi_cs_n_o   <= 1'b0;
                        bit_cnt       <= '0;
                        req_ready_o   <= 1'b0;
                        busy_o        <= 1'b1;
                    end
                end
                S_CMD, S_ADDR: begin
                    if (fall_stb) begin
                        tx_shift <= {tx_shift[30:0], 1'b0};
                        if (last_bit) begin
                            bit_cnt <= '0;
                            state   <= (state == S_CMD) ? S_ADDR : S_DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (state == S_ADDR && last_bit) begin
                            qspi_dq_o[0]  <= 1'b0;
                            qspi_dq_oe[0] <= 1'b0;
                        end else begin
                            qspi_dq_o[0]  <= tx_shift[31];
                        end
                    end
                end
                S_DATA: begin
                    if (rise_stb) begin
                        rx_shift <= {rx_shift[30:0], qspi_dq_i[1]};
                    end
                    if (fall_stb) begin
                        if (last_bit) begin
                            state       <= S_GAP;
                            qspi_cs_n_o <= 1'b1;
                            rsp_valid_o <= 1'b1;
                            // First byte received is the lowest address, so it lands in [7:0].
                            rsp_data_o  <= {rx_shift[7:0], rx_shift[15:8],
                                            rx_shift[23:16], rx_shift[31:24]};
                            gap_cnt     <= '0;
                            bit_cnt     <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    // The IDLE cycle before the next accept is the last CS-high cycle.
                    if (gap_cnt == {div_q, 1'b0}) begin
                        state       <= S_IDLE;
                        req_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    qspi_cs_n_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// tb/tb_qspi_flash_reader.sv - directed self-checking bench with a behavioural SPI flash
module tb_qspi_flash_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  div_i = 8'd0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [23:0] req_addr_i = 24'd0;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        busy_o;
    logic        qspi_cs_n_o;
    logic        qspi_sck_o;
    logic [3:0]  qspi_dq_o;
    logic [3:0]  qspi_dq_oe;
    logic [3:0]  qspi_dq_i = 4'b0000;

    qspi_flash_reader #(.DIV_W(8), .CMD_READ(8'h03)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_i       (div_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .busy_o      (busy_o),
        .qspi_cs_n_o (qspi_cs_n_o),
        .qspi_sck_o  (qspi_sck_o),
        .qspi_dq_o   (qspi_dq_o),
        .qspi_dq_oe  (qspi_dq_oe),
        .qspi_dq_i   (qspi_dq_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    int          rise_cnt = 0, fall_cnt = 0;
    logic [31:0] mosi = 0;
    int          hp_min = 0, hp_max = 0, last_tog = 0;
    int          cs_fall_time = 0, cs_rise_time = 0, cs_gap = 0;
    int          rsp_cnt = 0, rsp_time = 0;
    logic        rsp_cs = 1'b0;
    logic [31:0] rsp_log [0:15];
    int          overlap = 0, busy_nr = 0;
    logic        cs_prev = 1'b1, sck_prev = 1'b0;

    function automatic logic [7:0] mem(input logic [23:0] a);
        case (a)
            24'h000100: return 8'hEF;
            24'h000101: return 8'hBE;
            24'h000102: return 8'hAD;
            24'h000103: return 8'hDE;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
        endcase
    endfunction

    // Flash model and bus monitor; DUT outputs only move on posedge, so negedge sees every change.
    always @(negedge clk) begin
        int hp, idx;
        logic [7:0] b;
        if (cs_prev && !qspi_cs_n_o) begin
            rise_cnt = 0; fall_cnt = 0; mosi = 0;
            hp_min = 100000; hp_max = 0; last_tog = cyc;
            cs_fall_time = cyc; cs_gap = cyc - cs_rise_time;
        end
        if (!cs_prev && qspi_cs_n_o) cs_rise_time = cyc;
        if ((!qspi_cs_n_o || !cs_prev) && qspi_sck_o != sck_prev) begin
            hp = cyc - last_tog;
            if (hp < hp_min) hp_min = hp;
            if (hp > hp_max) hp_max = hp;
            last_tog = cyc;
            if (qspi_sck_o) begin
                if (rise_cnt < 32) mosi = {mosi[30:0], qspi_dq_o[0]};
                rise_cnt++;
            end else begin
                fall_cnt++;
                if (fall_cnt >= 32 && fall_cnt < 64) begin
                    idx = fall_cnt - 32;
                    b = mem(mosi[23:0] + 24'(idx / 8));
                    qspi_dq_i = {2'b00, b[7 - (idx % 8)], 1'b0};
                end
            end
        end
        if (rsp_valid_o) begin
            rsp_log[rsp_cnt[3:0]] = rsp_data_o;
            rsp_time = cyc;
            rsp_cs = qspi_cs_n_o;
            rsp_cnt++;
        end
        if (busy_o && req_ready_o) overlap++;
        if (busy_o && !req_ready_o) busy_nr++;
        cs_prev = qspi_cs_n_o;
        sck_prev = qspi_sck_o;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [23:0] a, input logic [7:0] d);
        @(negedge clk);
        req_addr_i = a; div_i = d; req_valid_i = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_rsp(input string tag, input int target, input int budget);
        int n = 0;
        while (rsp_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(rsp_cnt >= target), 64'd1);
    endtask

    task automatic wait_rise(input int target);
        int n = 0;
        while (rise_cnt < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("wait_rise_timeout", 64'(rise_cnt >= target), 64'd1);
    endtask

    initial begin
        int base, n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs_n", 64'(qspi_cs_n_o), 64'd1);
        check("rst_sck", 64'(qspi_sck_o), 64'd0);
        check("rst_dq_o", 64'(qspi_dq_o), 64'hC);
        check("rst_dq_oe", 64'(qspi_dq_oe), 64'hC);
        check("rst_ready", 64'(req_ready_o), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_rsp_data", 64'(rsp_data_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        rst_n = 1'b1;

        // div=0 read of 0x000100
        do_req(24'h000100, 8'd0);
        check("t1_cs_low", 64'(qspi_cs_n_o), 64'd0);
        check("t1_oe0", 64'(qspi_dq_oe), 64'hD);
        wait_rsp("t1_rsp_timeout", 1, 2000);
        repeat (4) @(negedge clk);
        check("t1_mosi", 64'(mosi), 64'h03000100);
        check("t1_data", 64'(rsp_log[0]), 64'hDEADBEEF);
        check("t1_latency", 64'(rsp_time - cs_fall_time), 64'd128);
        check("t1_rise_edges", 64'(rise_cnt), 64'd64);
        check("t1_fall_edges", 64'(fall_cnt), 64'd64);
        check("t1_cs_at_rsp", 64'(rsp_cs), 64'd1);
        check("t1_one_pulse", 64'(rsp_cnt), 64'd1);
        check("t1_data_hold", 64'(rsp_data_o), 64'hDEADBEEF);
        check("t1_dq_oe_after", 64'(qspi_dq_oe), 64'hC);

        // div=3 with div_i changed mid-ADDR
        do_req(24'h123456, 8'd3);
        wait_rise(12);
        div_i = 8'd0;
        wait_rsp("t2_rsp_timeout", 2, 4000);
        repeat (2) @(negedge clk);
        check("t2_mosi", 64'(mosi), 64'h03123456);
        check("t2_data", 64'(rsp_log[1]), 64'hDADBD4D5);
        check("t2_latency", 64'(rsp_time - cs_fall_time), 64'd512);
        check("t2_hp_min", 64'(hp_min), 64'd4);
        check("t2_hp_max", 64'(hp_max), 64'd4);
        repeat (10) @(negedge clk);

        // Back-to-back with req_valid_i held high, div=1
        base = rsp_cnt;
        overlap = 0; busy_nr = 0;
        @(negedge clk);
        req_addr_i = 24'h000010; div_i = 8'd1; req_valid_i = 1'b1;
        @(negedge clk);
        req_addr_i = 24'h000020;
        n = 0;
        while (!req_ready_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_ready_timeout", 64'(req_ready_o), 64'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
        wait_rsp("b2b_rsp_timeout", base + 2, 3000);
        repeat (2) @(negedge clk);
        check("b2b_data0", 64'(rsp_log[base]), 64'hB6B7B4B5);
        check("b2b_data1", 64'(rsp_log[base + 1]), 64'h86878485);
        check("b2b_mosi1", 64'(mosi), 64'h03000020);
        check("b2b_cs_gap", 64'(cs_gap), 64'd4);
        check("b2b_ready_busy_overlap", 64'(overlap), 64'd0);
        check("b2b_busy_not_ready", 64'(busy_nr > 0), 64'd1);
        repeat (8) @(negedge clk);

        // Asynchronous reset during ADDR
        base = rsp_cnt;
        do_req(24'hABCDEF, 8'd0);
        wait_rise(19);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_cs_n", 64'(qspi_cs_n_o), 64'd1);
        check("ar_sck", 64'(qspi_sck_o), 64'd0);
        check("ar_dq_o", 64'(qspi_dq_o), 64'hC);
        check("ar_dq_oe", 64'(qspi_dq_oe), 64'hC);
        check("ar_ready", 64'(req_ready_o), 64'd1);
        check("ar_busy", 64'(busy_o), 64'd0);
        check("ar_rsp_valid", 64'(rsp_valid_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("ar_no_rsp", 64'(rsp_cnt), 64'(base));
        do_req(24'hFFFFFF, 8'd0);
        wait_rsp("ar_rsp_timeout", base + 1, 2000);
        repeat (4) @(negedge clk);
        check("ar_mosi", 64'(mosi), 64'h03FFFFFF);
        check("ar_data", 64'(rsp_log[base]), 64'hA7A4A55A);
        check("ar_single_rsp", 64'(rsp_cnt), 64'(base + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
